// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display drivers.
// Segment byte layout is {dp,a,b,c,d,e,f,g}, active high; anodes are active low, all-ones = off.
package seg7_pkg;

  localparam int SEG_W          = 8;
  localparam int DEF_NUM_DIGITS = 8;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  typedef logic [6:0] glyph_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to 7-segment glyph {a,b,c,d,e,f,g}, active high; letters b and d are lowercase.
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output glyph_t     seg
);

  always_comb begin
    seg = 7'h00;
    unique case (hex)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      4'hF: seg = 7'h47;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with frame-synchronous double-buffered loads.
// Optional macro LEADING_ZERO_BLANK_EN: digits above the highest nonzero digit show only their dp.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [SEG_W-1:0]        seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  digits_t               act;
  digits_t               pend;
  logic [NUM_DIGITS-1:0] act_dp;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pend_full;

  logic   slot_end;
  logic   boundary;
  logic   blank;
  logic   hide;
  glyph_t glyph;

  assign slot_end   = en && (cnt == CNT_LAST);
  assign boundary   = slot_end && (idx == IDX_LAST);
  assign blank      = int'(cnt) < BLANK_CYCLES;
  assign data_ready = ~pend_full;

  hex_to_7seg u_dec (
    .hex (act[idx]),
    .seg (glyph)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_above;

  // Walk down from the top digit; a digit is blanked while everything at or above it is zero.
  always_comb begin
    lead_zero  = '0;
    zero_above = 1'b1;
    for (int unsigned k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_above              = zero_above && (act[IDX_W'(k)] == 4'h0);
      lead_zero[IDX_W'(k)]    = zero_above;
    end
  end

  assign hide = lead_zero[idx];
`else
  assign hide = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      act       <= '0;
      act_dp    <= '0;
      pend      <= '0;
      pend_dp   <= '0;
      pend_full <= 1'b0;
      an        <= '1;
      seg       <= SEG_BLANK;
    end else begin
      if (!en || blank) begin
        an  <= '1;
        seg <= SEG_BLANK;
      end else begin
        an  <= ~(NUM_DIGITS'(1) << idx);
        seg <= {act_dp[idx], hide ? 7'h00 : glyph};
      end

      if (en) begin
        if (slot_end) begin
          cnt <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      // A full pending buffer blocks new loads, so apply and accept never coincide.
      if (boundary && pend_full) begin
        act       <= pend;
        act_dp    <= pend_dp;
        pend_full <= 1'b0;
      end else if (data_valid && !pend_full) begin
        pend      <= data_in;
        pend_dp   <= dp_in;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 4-cycle slots, 1 blank cycle) against a frame-position model.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BL = 1;
  localparam int FRAME = ND * SD;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        data_valid;
  logic        data_ready;
  logic [7:0]  seg;
  logic [3:0]  an;

  int tests = 0;
  int fails = 0;

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .seg        (seg),
    .an         (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the frame, displayed word and one pending word.
  int          mpos;
  int          mi;
  logic [15:0] mact, mpend, msh;
  logic [3:0]  mact_dp, mpend_dp;
  bit          mfull, macc;
  logic [3:0]  m_an;
  logic [7:0]  m_seg;
  logic        m_rdy;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
      4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
      4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
      4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
    endcase
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      mpos = 0; mact = '0; mact_dp = '0; mpend = '0; mpend_dp = '0; mfull = 0; macc = 0;
      m_an = 4'hF; m_seg = 8'h00; m_rdy = 1'b1;
    end else begin
      macc = 0;
      if (en && (mpos % SD) >= BL) begin
        mi    = (mpos / SD) % ND;
        m_an  = 4'hF & ~(4'b0001 << mi);
        msh   = mact >> (4 * mi);
        m_seg = {mact_dp[mi], glyph(msh[3:0])};
`ifdef LEADING_ZERO_BLANK_EN
        if (mi > 0 && msh == 16'h0) m_seg[6:0] = 7'h00;
`endif
      end else begin
        m_an  = 4'hF;
        m_seg = 8'h00;
      end
      if (en && mpos == FRAME - 1 && mfull) begin
        mact = mpend; mact_dp = mpend_dp; mfull = 0;
      end else if (data_valid && !mfull) begin
        mpend = data_in; mpend_dp = dp_in; mfull = 1; macc = 1;
      end
      if (en) mpos = (mpos + 1) % FRAME;
      m_rdy = !mfull;
    end
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  task automatic test_reset();
    logic [3:0] ea;
    logic [7:0] es;
    rst_n = 1'b0; en = 1'b0; data_valid = 1'b0; data_in = '0; dp_in = '0;
    repeat (3) @(negedge clk);
    tests++; if (an !== 4'b1111) begin fails++; $display("FAIL reset_an got=%b want=1111", an); end
    tests++; if (seg !== 8'h00) begin fails++; $display("FAIL reset_seg got=%h want=00", seg); end
    tests++; if (data_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b want=1", data_ready); end
    rst_n = 1'b1; en = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      ea = (k % SD == 0) ? 4'b1111 : ~(4'b0001 << (k / SD));
      es = (k % SD == 0) ? 8'h00 : 8'h7E;
`ifdef LEADING_ZERO_BLANK_EN
      if (k >= SD) es = 8'h00;
`endif
      tests++; if (an !== ea || seg !== es) begin fails++; $display("FAIL zero_scan k=%0d an=%b seg=%h want an=%b seg=%h", k, an, seg, ea, es); end
    end
  endtask

  task automatic test_load();
    int ph = 0;
    data_in = 16'h1234; dp_in = 4'b0001; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    tests++; if (data_ready !== 1'b0) begin fails++; $display("FAIL load_ready_drop got=%b want=0", data_ready); end
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge clk);
      tests++; if (an !== m_an || seg !== m_seg || data_ready !== m_rdy) begin fails++; $display("FAIL load_cycle an=%b/%b seg=%h/%h rdy=%b/%b (got/want)", an, m_an, seg, m_seg, data_ready, m_rdy); end
      if (ph == 2 && mpos == 14) begin
        tests++; if (an !== 4'b0111 || seg !== 8'h30) begin fails++; $display("FAIL load_slot3 an=%b seg=%h want an=0111 seg=30", an, seg); end
        ph = 3;
      end
      if (ph == 1 && mpos == 6) begin
        tests++; if (an !== 4'b1101 || seg !== 8'h79) begin fails++; $display("FAIL load_slot1 an=%b seg=%h want an=1101 seg=79", an, seg); end
        ph = 2;
      end
      if (ph == 0 && !mfull && mpos == 2) begin
        tests++; if (an !== 4'b1110 || seg !== 8'hB3) begin fails++; $display("FAIL load_slot0 an=%b seg=%h want an=1110 seg=B3", an, seg); end
        ph = 1;
      end
    end
    tests++; if (ph != 3) begin fails++; $display("FAIL load_timeout phase=%0d want=3", ph); end
  endtask

  task automatic test_back_to_back();
    bit got = 0;
    int ph = 0;
    data_in = 16'h9999; dp_in = 4'b0000; data_valid = 1'b1;
    @(negedge clk);
    tests++; if (data_ready !== 1'b0) begin fails++; $display("FAIL b2b_first_accept got=%b want=0", data_ready); end
    data_in = 16'hABCD;
    for (int k = 0; k < 3 * FRAME && !got; k++) begin
      @(negedge clk);
      tests++; if (an !== m_an || seg !== m_seg || data_ready !== m_rdy) begin fails++; $display("FAIL b2b_hold an=%b/%b seg=%h/%h rdy=%b/%b (got/want)", an, m_an, seg, m_seg, data_ready, m_rdy); end
      if (k == 0) begin
        tests++; if (data_ready !== 1'b0) begin fails++; $display("FAIL b2b_held_off got=%b want=0", data_ready); end
      end
      if (macc) begin got = 1; data_valid = 1'b0; end
    end
    tests++; if (!got) begin fails++; $display("FAIL b2b_accept_timeout got=0 want=1"); end
    data_valid = 1'b0;
    for (int k = 0; k < 3 * FRAME && ph == 0; k++) begin
      @(negedge clk);
      tests++; if (an !== m_an || seg !== m_seg || data_ready !== m_rdy) begin fails++; $display("FAIL b2b_apply an=%b/%b seg=%h/%h rdy=%b/%b (got/want)", an, m_an, seg, m_seg, data_ready, m_rdy); end
      if (!mfull && mpos == 2) begin
        tests++; if (an !== 4'b1110 || seg !== 8'h3D) begin fails++; $display("FAIL b2b_slot0 an=%b seg=%h want an=1110 seg=3D", an, seg); end
        ph = 1;
      end
    end
    tests++; if (ph != 1) begin fails++; $display("FAIL b2b_apply_timeout phase=%0d want=1", ph); end
  endtask

  task automatic test_enable();
    int k = 0;
    while (mpos != 6 && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
      tests++; if (an !== m_an || seg !== m_seg || data_ready !== m_rdy) begin fails++; $display("FAIL en_wait an=%b/%b seg=%h/%h rdy=%b/%b (got/want)", an, m_an, seg, m_seg, data_ready, m_rdy); end
    end
    tests++; if (mpos != 6) begin fails++; $display("FAIL en_align_timeout pos=%0d want=6", mpos); end
    en = 1'b0;
    @(negedge clk);
    tests++; if (an !== 4'b1111 || seg !== 8'h00) begin fails++; $display("FAIL en_dark an=%b seg=%h want an=1111 seg=00", an, seg); end
    repeat (9) begin
      @(negedge clk);
      tests++; if (an !== m_an || seg !== m_seg || data_ready !== m_rdy) begin fails++; $display("FAIL en_frozen an=%b/%b seg=%h/%h rdy=%b/%b (got/want)", an, m_an, seg, m_seg, data_ready, m_rdy); end
    end
    en = 1'b1;
    @(negedge clk);
    tests++; if (an !== 4'b1101 || seg !== 8'h4E) begin fails++; $display("FAIL en_resume an=%b seg=%h want an=1101 seg=4E", an, seg); end
    repeat (20) begin
      @(negedge clk);
      tests++; if (an !== m_an || seg !== m_seg || data_ready !== m_rdy) begin fails++; $display("FAIL en_after an=%b/%b seg=%h/%h rdy=%b/%b (got/want)", an, m_an, seg, m_seg, data_ready, m_rdy); end
    end
  endtask

  task automatic test_reset_midframe();
    int ph = 0;
    data_in = 16'h5555; dp_in = 4'b1111; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    tests++; if (data_ready !== 1'b0) begin fails++; $display("FAIL rstmid_pending got=%b want=0", data_ready); end
    repeat (5) begin
      @(negedge clk);
      tests++; if (an !== m_an || seg !== m_seg || data_ready !== m_rdy) begin fails++; $display("FAIL rstmid_pre an=%b/%b seg=%h/%h rdy=%b/%b (got/want)", an, m_an, seg, m_seg, data_ready, m_rdy); end
    end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (an !== 4'b1111 || seg !== 8'h00 || data_ready !== 1'b1) begin fails++; $display("FAIL rstmid_async an=%b seg=%h rdy=%b want an=1111 seg=00 rdy=1", an, seg, data_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      tests++; if (an !== m_an || seg !== m_seg || data_ready !== m_rdy) begin fails++; $display("FAIL rstmid_post an=%b/%b seg=%h/%h rdy=%b/%b (got/want)", an, m_an, seg, m_seg, data_ready, m_rdy); end
      if (ph == 0 && mpos == 2) begin
        tests++; if (an !== 4'b1110 || seg !== 8'h7E) begin fails++; $display("FAIL rstmid_zero an=%b seg=%h want an=1110 seg=7E", an, seg); end
        ph = 1;
      end
    end
    tests++; if (ph != 1) begin fails++; $display("FAIL rstmid_timeout phase=%0d want=1", ph); end
  endtask

  task automatic test_leading_zero();
    int ph = 0;
    logic [7:0] upper;
`ifdef LEADING_ZERO_BLANK_EN
    upper = 8'h00;
`else
    upper = 8'h7E;
`endif
    data_in = 16'h0005; dp_in = 4'b0000; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge clk);
      tests++; if (an !== m_an || seg !== m_seg || data_ready !== m_rdy) begin fails++; $display("FAIL lzb_cycle an=%b/%b seg=%h/%h rdy=%b/%b (got/want)", an, m_an, seg, m_seg, data_ready, m_rdy); end
      if (ph == 2 && mpos == 10) begin
        tests++; if (an !== 4'b1011 || seg !== upper) begin fails++; $display("FAIL lzb_slot2 an=%b seg=%h want an=1011 seg=%h", an, seg, upper); end
        ph = 3;
      end
      if (ph == 1 && mpos == 6) begin
        tests++; if (an !== 4'b1101 || seg !== upper) begin fails++; $display("FAIL lzb_slot1 an=%b seg=%h want an=1101 seg=%h", an, seg, upper); end
        ph = 2;
      end
      if (ph == 0 && !mfull && mpos == 2) begin
        tests++; if (an !== 4'b1110 || seg !== 8'h5B) begin fails++; $display("FAIL lzb_slot0 an=%b seg=%h want an=1110 seg=5B", an, seg); end
        ph = 1;
      end
    end
    tests++; if (ph != 3) begin fails++; $display("FAIL lzb_timeout phase=%0d want=3", ph); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      tests++; if (an !== m_an || seg !== m_seg || data_ready !== m_rdy) begin fails++; $display("FAIL rand k=%0d an=%b/%b seg=%h/%h rdy=%b/%b (got/want)", k, an, m_an, seg, m_seg, data_ready, m_rdy); end
      en = ($urandom % 8) != 0;
      if (macc) data_valid = 1'b0;
      if (!data_valid && ($urandom % 4) == 0) begin
        data_valid = 1'b1;
        data_in    = 16'($urandom);
        dp_in      = 4'($urandom);
      end
    end
    data_valid = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; data_valid = 1'b0; data_in = '0; dp_in = '0;
    test_reset();
    test_load();
    test_back_to_back();
    test_enable();
    test_reset_midframe();
    test_leading_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
